dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port Data_Memory between two requesters: the single-cycle core's load/store path and an external DMA/loader port.
- Owns the memory address, write-data and write-enable lines.
- Stalls the core (PC hold, RegWrite/MemWrite suppression upstream) while the DMA owns memory.
- Enforces bounded DMA bursts and bounded core starvation of the DMA.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- MAX_BURST, 4, maximum DMA beats per ownership period (>=1).
- MAX_WAIT, 2, consecutive cycles the DMA may be blocked by core traffic before forced handover (>=1).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- core_req  in  1  core issues load or store this cycle.
- core_we  in  1  core access is a store.
- core_addr  in  ADDR_W  core byte address (ALUResult).
- core_wdata  in  DATA_W  core store data (RD2).
- core_rdata  out  DATA_W  load data to core, equals mem_rdata.
- core_stall  out  1  core must hold PC and suppress writes this cycle.
- dma_req  in  1  DMA beat request; addr/we/wdata valid while high.
- dma_we  in  1  DMA beat is a write.
- dma_addr  in  ADDR_W  DMA byte address.
- dma_wdata  in  DATA_W  DMA write data.
- dma_last  in  1  current beat is the final beat of the DMA transfer.
- dma_gnt  out  1  beat accepted this cycle (dma_req & dma_gnt = beat).
- dma_rdata  out  DATA_W  read data, equals mem_rdata.
- mem_addr  out  ADDR_W  to Data_Memory A.
- mem_wdata  out  DATA_W  to Data_Memory WD.
- mem_we  out  1  to Data_Memory WE.
- mem_rdata  in  DATA_W  from Data_Memory RD (combinational read).
- owner  out  1  0 = core owns memory, 1 = DMA owns memory.

Behaviour:

Reset
- rst=0 forces, immediately (async): state=OWN_CORE, beat_cnt=0, wait_cnt=0.
- Output values under reset: owner=0, dma_gnt=0, core_stall=0, mem_we=core_req&core_we. There is no other registered output.

State OWN_CORE
- mem_* driven from core_*.
- mem_we = core_req & core_we.
- core_stall=0, dma_gnt=0.
- wait_cnt increments when dma_req & core_req; clears when dma_req=0.
- Next state is OWN_DMA when dma_req & (!core_req | wait_cnt==MAX_WAIT-1); otherwise stay.
- The handover edge itself serves the core. The DMA receives no beat in the cycle the transition is decided (1-cycle grant latency).

State OWN_DMA
- mem_* driven from dma_*.
- dma_gnt = dma_req.
- mem_we = dma_req & dma_we.
- core_stall = core_req.
- Each beat increments beat_cnt.
- Return to OWN_CORE on the edge after any of:
  - a beat with dma_last=1;
  - a beat with beat_cnt==MAX_BURST-1;
  - a cycle with dma_req=0.
- On exit: beat_cnt=0, wait_cnt=0.
- The mandatory OWN_CORE cycle after exit gives the core at least one service slot per MAX_BURST beats.

Boundary cases
- dma_last on the MAX_BURST-th beat: a single exit, no extra behaviour.
- Re-request after a forced cap: with core_req=0, the DMA is re-granted after exactly one OWN_CORE cycle.
- Stalled core: the stalled core presents the same request every cycle. The arbiter does not latch core inputs.
- Reset mid-burst: the in-flight beat is dropped. mem_we falls with rst (DMA-side), since state becomes OWN_CORE asynchronously.
- Widths: counters are clog2(MAX_BURST+1) and clog2(MAX_WAIT+1) bits and never wrap.

Decomposition:
- Package dmem_arb_pkg holds:
  - OWN_CORE=1'b0, OWN_DMA=1'b1;
  - default ADDR_W/DATA_W;
  - a counter-width function (clog2).
- One combinational sub-module, dmem_port_mux: selects addr/wdata/we by owner and gates we by req.
- The FSM and counters stay in the top.

Test Plan:
1. Store, DMA idle: core_req=1, we=1, addr=0x20, wdata=0xDEADBEEF. Expect mem_we=1 the same cycle, core_stall=0, and a following read of 0x20 returning 0xDEADBEEF.
2. DMA-only burst: writes 0x11, 0x22, 0x33 to 0x10/0x14/0x18, dma_last on the 3rd beat. Expect:
   - dma_gnt=0 in cycle 1, then 1 in cycles 2–4;
   - owner back to 0 at cycle 5;
   - memory holding the three words.
3. Contention, MAX_WAIT=2, core_req and dma_req both held high:
   - core served 2 cycles, then owner=1;
   - core_stall=1 throughout the DMA beats;
   - core_stall=0 on the first cycle back in OWN_CORE.
4. Burst cap, MAX_BURST=4: dma_req held for 10 reads, core idle, no dma_last.
   - Grant pattern is 4 beats, 1 idle, 4 beats, 1 idle, 2 beats.
   - dma_rdata matches memory on every beat.
5. DMA abort: dma_req drops after 2 of 4 beats. Expect owner=0 on the next edge and beat_cnt=0; the next burst gets the full 4 beats.
6. Reset mid-burst: assert rst=0 between edges in OWN_DMA. Expect, without waiting for a clock:
   - dma_gnt=0, owner=0, core_stall=0;
   - no memory write on the following edge.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter slice.
// Ownership encoding, default bus widths and counter sizing.
package dmem_arb_pkg;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_DMA  = 1'b1
    } own_e;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    // Bits needed to hold values 0..n inclusive; never less than one bit.
    function automatic int cnt_w(input int n);
        int w;
        w = 1;
        while ((1 << w) < (n + 1)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/dmem_port_mux.sv
// Combinational memory-port steering: picks the owning requester's
// address, write data and write enable (enable gated by that requester's req).
module dmem_port_mux
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              owner,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we
);

    always_comb begin
        mem_addr  = core_addr;
        mem_wdata = core_wdata;
        mem_we    = core_req & core_we;
        if (owner == OWN_DMA) begin
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
            mem_we    = dma_req & dma_we;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the core load/store path
// and a DMA port, with bounded DMA bursts and bounded DMA starvation.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_BURST = 4,
    parameter int MAX_WAIT  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    input  logic              dma_last,
    output logic              dma_gnt,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              owner
);

    localparam int BW = cnt_w(MAX_BURST);
    localparam int WW = cnt_w(MAX_WAIT);
    localparam logic [BW-1:0] BEAT_LAST = BW'(MAX_BURST - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);
    localparam logic [WW-1:0] WAIT_SAT  = WW'(MAX_WAIT);

    own_e          state;
    own_e          state_nxt;
    logic [BW-1:0] beat_cnt;
    logic [WW-1:0] wait_cnt;
    logic          handover;
    logic          dma_exit;

    // Handover is decided in OWN_CORE; the DMA's first beat lands one cycle later.
    assign handover = dma_req & (~core_req | (wait_cnt == WAIT_LAST));
    // In OWN_DMA every cycle with dma_req high is a beat, so req=0 also ends ownership.
    assign dma_exit = ~dma_req | dma_last | (beat_cnt == BEAT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= OWN_CORE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            OWN_CORE: if (handover) state_nxt = OWN_DMA;
            OWN_DMA:  if (dma_exit) state_nxt = OWN_CORE;
            default:  state_nxt = OWN_CORE;
        endcase
    end

    always_comb begin
        owner      = state;
        dma_gnt    = 1'b0;
        core_stall = 1'b0;
        if (state == OWN_DMA) begin
            dma_gnt    = dma_req;
            core_stall = core_req;
        end
    end

    // Saturating counters so neither can wrap regardless of parameters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_cnt <= '0;
            wait_cnt <= '0;
        end else if (state == OWN_CORE) begin
            beat_cnt <= '0;
            if (!dma_req) begin
                wait_cnt <= '0;
            end else if (core_req && (wait_cnt != WAIT_SAT)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end else begin
            if (dma_exit) begin
                beat_cnt <= '0;
                wait_cnt <= '0;
            end else begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    dmem_port_mux #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_port_mux (
        .owner      (state),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .dma_req    (dma_req),
        .dma_we     (dma_we),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we)
    );

    assign core_rdata = mem_rdata;
    assign dma_rdata  = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small combinational-read memory
// attached to the mem_* port.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req, core_we;
    logic [31:0] core_addr, core_wdata, core_rdata;
    logic        core_stall;
    logic        dma_req, dma_we, dma_last, dma_gnt;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we, owner;
    logic        init_mem;
    logic [31:0] mem [0:63];
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'hA000_0000 + i;
        end else if (mem_we) begin
            mem[mem_addr[7:2]] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_addr[7:2]];

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(4), .MAX_WAIT(2)) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_rdata(core_rdata), .core_stall(core_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_last(dma_last), .dma_gnt(dma_gnt),
        .dma_rdata(dma_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_rdata(mem_rdata), .owner(owner)
    );

    task automatic test_reset;
        rst = 1'b0; init_mem = 1'b1;
        core_req = 1'b1; core_we = 1'b1; core_addr = 32'h0; core_wdata = 32'h0;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h0; dma_wdata = 32'h0; dma_last = 1'b0;
        #1;
        total++; if (owner !== 1'b0) begin bad++; $display("FAIL reset_owner got=%b exp=0", owner); end
        total++; if (dma_gnt !== 1'b0) begin bad++; $display("FAIL reset_gnt got=%b exp=0", dma_gnt); end
        total++; if (core_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", core_stall); end
        total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL reset_mem_we got=%b exp=1", mem_we); end
        @(negedge clk);
        @(negedge clk);
        init_mem = 1'b0; core_req = 1'b0; core_we = 1'b0; dma_req = 1'b0; dma_we = 1'b0;
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_core_store;
        core_req = 1'b1; core_we = 1'b1; core_addr = 32'h20; core_wdata = 32'hDEADBEEF;
        #1;
        total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL store_we got=%b exp=1", mem_we); end
        total++; if (core_stall !== 1'b0) begin bad++; $display("FAIL store_stall got=%b exp=0", core_stall); end
        total++; if (mem_addr !== 32'h20) begin bad++; $display("FAIL store_addr got=%h exp=20", mem_addr); end
        @(negedge clk);
        core_we = 1'b0;
        #1;
        total++; if (core_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL load_back got=%h exp=deadbeef", core_rdata); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL load_we got=%b exp=0", mem_we); end
        @(negedge clk);
        core_req = 1'b0;
    endtask

    task automatic test_dma_burst;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h10; dma_wdata = 32'h11; dma_last = 1'b0;
        #1;
        total++; if (dma_gnt !== 1'b0) begin bad++; $display("FAIL burst_c1_gnt got=%b exp=0", dma_gnt); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL burst_c1_we got=%b exp=0", mem_we); end
        @(negedge clk); #1;
        total++; if (dma_gnt !== 1'b1) begin bad++; $display("FAIL burst_c2_gnt got=%b exp=1", dma_gnt); end
        total++; if (owner !== 1'b1) begin bad++; $display("FAIL burst_c2_owner got=%b exp=1", owner); end
        total++; if (mem_addr !== 32'h10) begin bad++; $display("FAIL burst_c2_addr got=%h exp=10", mem_addr); end
        @(negedge clk);
        dma_addr = 32'h14; dma_wdata = 32'h22;
        #1;
        total++; if (dma_gnt !== 1'b1) begin bad++; $display("FAIL burst_c3_gnt got=%b exp=1", dma_gnt); end
        @(negedge clk);
        dma_addr = 32'h18; dma_wdata = 32'h33; dma_last = 1'b1;
        #1;
        total++; if (dma_gnt !== 1'b1) begin bad++; $display("FAIL burst_c4_gnt got=%b exp=1", dma_gnt); end
        total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL burst_c4_we got=%b exp=1", mem_we); end
        @(negedge clk);
        dma_req = 1'b0; dma_last = 1'b0; dma_we = 1'b0;
        #1;
        total++; if (owner !== 1'b0) begin bad++; $display("FAIL burst_c5_owner got=%b exp=0", owner); end
        total++; if (mem[4] !== 32'h11) begin bad++; $display("FAIL burst_mem10 got=%h exp=11", mem[4]); end
        total++; if (mem[5] !== 32'h22) begin bad++; $display("FAIL burst_mem14 got=%h exp=22", mem[5]); end
        total++; if (mem[6] !== 32'h33) begin bad++; $display("FAIL burst_mem18 got=%h exp=33", mem[6]); end
        @(negedge clk);
    endtask

    task automatic test_contention;
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h20;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h40; dma_wdata = 32'h44; dma_last = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            #1;
            total++; if (owner !== 1'b0) begin bad++; $display("FAIL cont_c%0d_owner got=%b exp=0", c, owner); end
            total++; if (core_stall !== 1'b0) begin bad++; $display("FAIL cont_c%0d_stall got=%b exp=0", c, core_stall); end
            total++; if (core_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL cont_c%0d_rdata got=%h exp=deadbeef", c, core_rdata); end
            @(negedge clk);
        end
        for (int b = 0; b < 3; b++) begin
            dma_addr = 32'h40 + 4 * b; dma_wdata = 32'h44 + 32'h11 * b; dma_last = (b == 2);
            #1;
            total++; if (owner !== 1'b1) begin bad++; $display("FAIL cont_beat%0d_owner got=%b exp=1", b, owner); end
            total++; if (core_stall !== 1'b1) begin bad++; $display("FAIL cont_beat%0d_stall got=%b exp=1", b, core_stall); end
            total++; if (dma_gnt !== 1'b1) begin bad++; $display("FAIL cont_beat%0d_gnt got=%b exp=1", b, dma_gnt); end
            @(negedge clk);
        end
        dma_req = 1'b0; dma_last = 1'b0; dma_we = 1'b0;
        #1;
        total++; if (owner !== 1'b0) begin bad++; $display("FAIL cont_back_owner got=%b exp=0", owner); end
        total++; if (core_stall !== 1'b0) begin bad++; $display("FAIL cont_back_stall got=%b exp=0", core_stall); end
        total++; if (core_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL cont_back_rdata got=%h exp=deadbeef", core_rdata); end
        total++; if (mem[18] !== 32'h66) begin bad++; $display("FAIL cont_mem48 got=%h exp=66", mem[18]); end
        @(negedge clk);
        core_req = 1'b0;
    endtask

    task automatic test_burst_cap;
        int gp [13] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1};
        int beat = 0;
        dma_we = 1'b0; dma_last = 1'b0;
        for (int c = 0; c < 13; c++) begin
            dma_req = (beat < 10); dma_addr = 32'h80 + 4 * beat;
            #1;
            total++; if (dma_gnt !== gp[c][0]) begin bad++; $display("FAIL cap_c%0d_gnt got=%b exp=%0d", c, dma_gnt, gp[c]); end
            if (gp[c] == 1) begin
                total++;
                if (dma_rdata !== 32'hA000_0020 + beat) begin
                    bad++; $display("FAIL cap_beat%0d_rdata got=%h exp=%h", beat, dma_rdata, 32'hA000_0020 + beat);
                end
                beat++;
            end
            @(negedge clk);
        end
        dma_req = 1'b0;
        #1;
        total++; if (owner !== 1'b1) begin bad++; $display("FAIL cap_tail_owner got=%b exp=1", owner); end
        @(negedge clk); #1;
        total++; if (owner !== 1'b0) begin bad++; $display("FAIL cap_end_owner got=%b exp=0", owner); end
        @(negedge clk);
    endtask

    task automatic test_abort;
        int gp [11] = '{0, 1, 1, 0, 0, 0, 1, 1, 1, 1, 0};
        int rq [11] = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 0};
        int ow [11] = '{0, 1, 1, 1, 0, 0, 1, 1, 1, 1, 0};
        dma_we = 1'b0; dma_last = 1'b0; dma_addr = 32'h80;
        for (int c = 0; c < 11; c++) begin
            dma_req = rq[c][0];
            #1;
            total++; if (dma_gnt !== gp[c][0]) begin bad++; $display("FAIL abort_c%0d_gnt got=%b exp=%0d", c, dma_gnt, gp[c]); end
            total++; if (owner !== ow[c][0]) begin bad++; $display("FAIL abort_c%0d_owner got=%b exp=%0d", c, owner, ow[c]); end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_burst;
        core_req = 1'b0; core_we = 1'b0; core_addr = 32'h20;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'hC0; dma_wdata = 32'h55; dma_last = 1'b0;
        #1;
        total++; if (dma_gnt !== 1'b0) begin bad++; $display("FAIL rmb_c1_gnt got=%b exp=0", dma_gnt); end
        @(negedge clk);
        core_req = 1'b1;
        #1;
        total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL rmb_c2_we got=%b exp=1", mem_we); end
        total++; if (core_stall !== 1'b1) begin bad++; $display("FAIL rmb_c2_stall got=%b exp=1", core_stall); end
        #2 rst = 1'b0;
        #1;
        total++; if (dma_gnt !== 1'b0) begin bad++; $display("FAIL rmb_async_gnt got=%b exp=0", dma_gnt); end
        total++; if (owner !== 1'b0) begin bad++; $display("FAIL rmb_async_owner got=%b exp=0", owner); end
        total++; if (core_stall !== 1'b0) begin bad++; $display("FAIL rmb_async_stall got=%b exp=0", core_stall); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rmb_async_we got=%b exp=0", mem_we); end
        @(posedge clk); #1;
        total++; if (mem[48] !== 32'hA000_0030) begin bad++; $display("FAIL rmb_no_write got=%h exp=a0000030", mem[48]); end
        @(negedge clk);
        rst = 1'b1; dma_req = 1'b0; core_req = 1'b0;
        #1;
        total++; if (owner !== 1'b0) begin bad++; $display("FAIL rmb_release_owner got=%b exp=0", owner); end
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_core_store;
        test_dma_burst;
        test_contention;
        test_burst_cap;
        test_abort;
        test_reset_mid_burst;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
